router_b_pipe: RTL and testbench
================================

// Module: router_b_pipe
// PURPOSE
//  Parametrised, registered successor to the operand router. It feeds R/S/I operands to the
//  Kalman-filter arithmetic core from an N-entry source bus (A/B/RQ/RD and more).
//  Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure,
//  and a loadable immediate register.
//  Sits between register-file/operand fetch and the MAC/ALU stage.
// PARAMETERS
//  W     24                 operand width (fixed-point word)
//  NSRC  4                  number of W-bit sources on src_bus (>=2)
//  SELW  $clog2(NSRC+2)     width of sel_R/sel_S; derived, do not override
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset, asynchronous, active-high
//  in_valid   in   1        request carries valid selection
//  in_ready   out  1        router can accept; request transfers on in_valid&&in_ready
//  src_bus    in   NSRC*W   sources; src k = src_bus[k*W +: W]
//  sel_R      in   SELW     R source: 0..NSRC-1 = src k; NSRC = zero; NSRC+1 = all-ones; else zero
//  sel_S      in   SELW     S source, same encoding as sel_R
//  inv_R      in   1        bitwise-invert selected R
//  inv_S      in   1        bitwise-invert selected S
//  sel_I      in   2        immediate: 0 = 0; 1 = 1; 2 = all-ones; 3 = imm_reg
//  imm_we     in   1        load imm_reg from imm_data (independent of handshake)
//  imm_data   in   W        immediate load value
//  out_valid  out  1        R/S/I/msb_* hold a valid operand set
//  out_ready  in   1        consumer accepts; transfers on out_valid&&out_ready
//  R, S, I    out  W        registered operands
//  msb_R      out  1        == R[W-1]
//  msb_S      out  1        == S[W-1]
// BEHAVIOUR
//  - Reset (async, rst=1): both buffer entries empty; out_valid=0; R=S=I=0; msb_R=msb_S=0;
//    imm_reg=0; in_ready=1 on the first cycle after deassertion. Reset mid-transfer drops
//    all buffered operands without emitting them.
//  - Capture: on in_valid&&in_ready, compute the payload {R,S,I} from src_bus/sel/inv/imm_reg
//    sampled that cycle.
//  - Inversion: applied after selection, so inv_R with sel_R=NSRC gives all-ones.
//  - Latency: 1 cycle. When the output register is empty, out_valid rises on the edge after
//    capture.
//  - Skid buffer (2 entries: out reg + skid reg):
//    - in_ready = !skid_full, registered (no combinational path from out_ready to in_ready).
//    - Out reg stalled (out_valid && !out_ready) and a capture occurs -> payload goes to skid.
//    - On out transfer with skid full -> skid moves to out reg. The same-cycle capture is
//      impossible because in_ready=0.
//    - On out transfer with skid empty and a capture -> new payload goes to out reg directly.
//    - Sustains 1 transfer/cycle when out_ready=1. Strict FIFO order. Never drops or
//      duplicates.
//  - Output stability: R/S/I/msb_* hold constant while out_valid && !out_ready.
//  - imm_reg: loads imm_data on any edge with imm_we=1. A capture with sel_I=3 in the same
//    cycle uses the OLD imm_reg value.
//  - msb_R/msb_S: taken from the final (possibly inverted) stored operand, never from the
//    raw source.
//  - Out-of-range sel_R/sel_S (> NSRC+1, possible when NSRC+2 is not a power of 2) -> zero.
//    Not an error.
// STRUCTURE
//  - Shared include router_defs.vh: SEL_ZERO/SEL_ONES offset macros (relative to NSRC),
//    SELI_ZERO=0, SELI_ONE=1, SELI_ONES=2, SELI_IMM=3.
//  - One sub-module router_skid #(.DW(3*W)): generic 2-entry valid/ready skid buffer with
//    async active-high rst. Carry msb_* as R[W-1]/S[W-1] at the output; do not store them.
//  - Selection/inversion/immediate muxing and imm_reg are inline in router_b_pipe.
// TESTING  (W=24, NSRC=4; src0=123456, src1=ABCDEF, src2=0FF00D, src3=C0FFEE)
//  1. Exhaustive select:
//     - Stimulus: sweep sel_R/sel_S 0..7, inv_R/inv_S, sel_I 0..2, out_ready=1.
//     - Response: each output 1 cycle later. sel_R=1 -> R=ABCDEF. sel_R=4 -> R=000000.
//       sel_R=5,inv_R=1 -> R=000000. sel_R=6/7 -> R=000000. msb_* always == MSB.
//  2. Back-pressure:
//     - Stimulus: 8 back-to-back requests, out_ready=0 for 5 cycles.
//     - Response: exactly 2 accepted, then in_ready=0. Outputs stable and equal to request 1.
//       After release, all 8 emerge in order with no gaps once out_ready=1.
//  3. Throughput:
//     - Stimulus: out_ready=1, in_valid=1 for 100 cycles.
//     - Response: 100 transfers in 101 cycles; in_ready never drops.
//  4. Immediate hazard:
//     - Stimulus: imm_reg=000005; same cycle imm_we=1 with imm_data=7FFFFF and capture sel_I=3.
//     - Response: I=000005. Next capture with sel_I=3 -> I=7FFFFF.
//  5. Reset mid-stream:
//     - Stimulus: both entries full, assert rst asynchronously between edges.
//     - Response: out_valid=0 and R=S=I=0 immediately; imm_reg=0; no stale operand emitted
//       after release.
//  6. Random scoreboard:
//     - Stimulus: 10k cycles of random in_valid/out_ready/imm_we.
//     - Response: output stream matches the reference-model FIFO exactly; no X on outputs
//       after reset.

Source files
------------

// File: rtl/router_b_pipe_pkg.sv
// Shared selection encodings for the operand router.
package router_b_pipe_pkg;

  // R/S select codes above the source range, as offsets from NSRC
  localparam int SEL_ZERO_OFS = 0;
  localparam int SEL_ONES_OFS = 1;

  // Immediate select codes
  localparam logic [1:0] SELI_ZERO = 2'd0;
  localparam logic [1:0] SELI_ONE  = 2'd1;
  localparam logic [1:0] SELI_ONES = 2'd2;
  localparam logic [1:0] SELI_IMM  = 2'd3;

endpackage

// File: rtl/router_skid.sv
// Generic 2-entry valid/ready skid buffer: an output register plus one skid register.
// in_ready depends only on stored state, so out_ready never reaches it combinationally.
module router_skid #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          skid_valid;
  logic [DW-1:0] skid_data;
  logic          in_fire;
  logic          out_fire;

  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Move payloads through out reg / skid reg, preserving arrival order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (skid_valid) begin
      // No capture is possible here since in_ready is low
      if (out_fire) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid || out_ready) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/router_b_pipe.sv
// Registered operand router: selects R/S/I operands for the arithmetic core from a
// source bus, with optional inversion, a loadable immediate and a skid-buffered output.
module router_b_pipe
  import router_b_pipe_pkg::*;
#(
  parameter int W    = 24,
  parameter int NSRC = 4,
  parameter int SELW = $clog2(NSRC + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NSRC*W-1:0] src_bus,
  input  logic [SELW-1:0]   sel_R,
  input  logic [SELW-1:0]   sel_S,
  input  logic              inv_R,
  input  logic              inv_S,
  input  logic [1:0]        sel_I,
  input  logic              imm_we,
  input  logic [W-1:0]      imm_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      R,
  output logic [W-1:0]      S,
  output logic [W-1:0]      I,
  output logic              msb_R,
  output logic              msb_S
);

  logic [W-1:0]   imm_reg;
  logic [W-1:0]   r_sel;
  logic [W-1:0]   s_sel;
  logic [W-1:0]   i_sel;
  logic [3*W-1:0] payload;
  logic [3*W-1:0] out_data;

  // Immediate register; a same-edge capture still sees the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) imm_reg <= '0;
    else if (imm_we) imm_reg <= imm_data;
  end

  // Source selection for R and S; unlisted codes fall through to zero
  always_comb begin
    r_sel = '0;
    s_sel = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel_R == SELW'(k)) r_sel = src_bus[k*W +: W];
      if (sel_S == SELW'(k)) s_sel = src_bus[k*W +: W];
    end
    if (sel_R == SELW'(NSRC + SEL_ONES_OFS)) r_sel = '1;
    if (sel_S == SELW'(NSRC + SEL_ONES_OFS)) s_sel = '1;
  end

  // Immediate selection
  always_comb begin
    unique case (sel_I)
      SELI_ZERO: i_sel = '0;
      SELI_ONE:  i_sel = W'(1);
      SELI_ONES: i_sel = '1;
      default:   i_sel = imm_reg;
    endcase
  end

  // Inversion applies after selection
  assign payload = {(inv_R ? ~r_sel : r_sel), (inv_S ? ~s_sel : s_sel), i_sel};

  router_skid #(.DW(3 * W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign {R, S, I} = out_data;
  assign msb_R     = R[W-1];
  assign msb_S     = S[W-1];

endmodule

// File: tb/tb_router_b_pipe.sv
module tb_router_b_pipe;

  localparam int W    = 24;
  localparam int NSRC = 4;
  localparam int SELW = 3;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [NSRC*W-1:0] src_bus;
  logic [SELW-1:0]   sel_R;
  logic [SELW-1:0]   sel_S;
  logic              inv_R;
  logic              inv_S;
  logic [1:0]        sel_I;
  logic              imm_we;
  logic [W-1:0]      imm_data;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      R;
  logic [W-1:0]      S;
  logic [W-1:0]      I;
  logic              msb_R;
  logic              msb_S;

  int n_tests;
  int n_fail;
  logic [W-1:0] imm_model;

  router_b_pipe #(.W(W), .NSRC(NSRC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .src_bus(src_bus),
    .sel_R(sel_R), .sel_S(sel_S), .inv_R(inv_R), .inv_S(inv_S), .sel_I(sel_I),
    .imm_we(imm_we), .imm_data(imm_data), .out_valid(out_valid), .out_ready(out_ready),
    .R(R), .S(S), .I(I), .msb_R(msb_R), .msb_S(msb_S)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] ref_op(input int sel, input bit inv);
    logic [W-1:0] v;
    case (sel)
      0: v = 24'h123456;
      1: v = 24'hABCDEF;
      2: v = 24'h0FF00D;
      3: v = 24'hC0FFEE;
      5: v = 24'hFFFFFF;
      default: v = 24'h000000;
    endcase
    return inv ? ~v : v;
  endfunction

  function automatic logic [W-1:0] ref_imm(input int sel, input logic [W-1:0] imm);
    case (sel)
      0: return 24'h000000;
      1: return 24'h000001;
      2: return 24'hFFFFFF;
      default: return imm;
    endcase
  endfunction

  task automatic idle_inputs();
    in_valid = 0; sel_R = 0; sel_S = 0; inv_R = 0; inv_S = 0;
    sel_I = 0; imm_we = 0; imm_data = 0; out_ready = 1;
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #12;
    n_tests++;
    if (out_valid !== 1'b0 || R !== 0 || S !== 0 || I !== 0 || msb_R !== 0 || msb_S !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: out_valid=%b R=%h S=%h I=%h msb=%b%b, need all zero",
               out_valid, R, S, I, msb_R, msb_S);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b out_valid=%b, need 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_select();
    logic [W-1:0] er, es, ei;
    bit have;
    have = 0;
    out_ready = 1;
    for (int r = 0; r < 8; r++) begin
      for (int v = 0; v < 2; v++) begin
        @(negedge clk);
        if (have) begin
          n_tests++;
          if (out_valid !== 1'b1 || R !== er || S !== es || I !== ei ||
              msb_R !== er[W-1] || msb_S !== es[W-1]) begin
            n_fail++;
            $display("FAIL select: got v=%b R=%h S=%h I=%h msb=%b%b, need R=%h S=%h I=%h",
                     out_valid, R, S, I, msb_R, msb_S, er, es, ei);
          end
        end
        in_valid = 1;
        sel_R = SELW'(r); inv_R = v[0];
        sel_S = SELW'(7 - r); inv_S = ~v[0];
        sel_I = 2'(r % 3);
        er = ref_op(r, v[0]);
        es = ref_op(7 - r, ~v[0]);
        ei = ref_imm(r % 3, imm_model);
        have = 1;
      end
    end
    @(negedge clk);
    in_valid = 0;
    n_tests++;
    if (out_valid !== 1'b1 || R !== er || S !== es || I !== ei) begin
      n_fail++;
      $display("FAIL select_last: got R=%h S=%h I=%h, need R=%h S=%h I=%h", R, S, I, er, es, ei);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_r [8];
    int idx, got, accepted;
    for (int i = 0; i < 8; i++) exp_r[i] = ref_op(i % 4, i >= 4);
    idx = 0; accepted = 0; got = 0;
    out_ready = 0;
    sel_S = 0; inv_S = 0; sel_I = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        n_tests++;
        if (out_valid !== 1'b1 || R !== exp_r[0]) begin
          n_fail++;
          $display("FAIL bp_stable: v=%b R=%h, need v=1 R=%h", out_valid, R, exp_r[0]);
        end
      end
      in_valid = 1; sel_R = SELW'(idx % 4); inv_R = (idx >= 4);
      if (in_ready) begin idx++; accepted++; end
    end
    @(negedge clk);
    n_tests++;
    if (accepted !== 2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: accepted=%0d in_ready=%b, need 2/0", accepted, in_ready);
    end
    out_ready = 1;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (out_valid !== 1'b1) begin
        n_tests++; n_fail++;
        $display("FAIL bp_gap: out_valid=0 at output %0d, need 1", got);
      end else begin
        n_tests++;
        if (R !== exp_r[got]) begin
          n_fail++;
          $display("FAIL bp_order: out %0d R=%h, need %h", got, R, exp_r[got]);
        end
        got++;
      end
      if (idx < 8) begin
        in_valid = 1; sel_R = SELW'(idx % 4); inv_R = (idx >= 4);
        if (in_ready) idx++;
      end else in_valid = 0;
      @(negedge clk);
    end
    n_tests++;
    if (got !== 8) begin
      n_fail++;
      $display("FAIL bp_count: got %0d outputs, need 8", got);
    end
    drain();
  endtask

  task automatic test_throughput();
    int outs, drops;
    outs = 0; drops = 0;
    out_ready = 1; sel_R = 1; inv_R = 0;
    for (int c = 0; c < 101; c++) begin
      @(negedge clk);
      if (out_valid) outs++;
      in_valid = (c < 100);
      if (in_valid && !in_ready) drops++;
    end
    n_tests++;
    if (outs !== 100 || drops !== 0) begin
      n_fail++;
      $display("FAIL throughput: outputs=%0d ready_drops=%0d, need 100/0", outs, drops);
    end
    drain();
  endtask

  task automatic test_imm_hazard();
    @(negedge clk);
    in_valid = 0; imm_we = 1; imm_data = 24'h000005;
    @(negedge clk);
    imm_data = 24'h7FFFFF; in_valid = 1; sel_I = 3;
    @(negedge clk);
    imm_we = 0;
    n_tests++;
    if (out_valid !== 1'b1 || I !== 24'h000005) begin
      n_fail++;
      $display("FAIL imm_old: v=%b I=%h, need 000005", out_valid, I);
    end
    @(negedge clk);
    in_valid = 0;
    n_tests++;
    if (out_valid !== 1'b1 || I !== 24'h7FFFFF) begin
      n_fail++;
      $display("FAIL imm_new: v=%b I=%h, need 7fffff", out_valid, I);
    end
    imm_model = 24'h7FFFFF;
    drain();
  endtask

  task automatic test_reset_midstream();
    out_ready = 0; in_valid = 1; sel_R = 3; sel_S = 1; sel_I = 2; inv_R = 0; inv_S = 0;
    for (int c = 0; c < 10 && in_ready; c++) @(negedge clk);
    in_valid = 0;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_full: in_ready=%b out_valid=%b, need 0/1", in_ready, out_valid);
    end
    #2 rst = 1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || R !== 0 || S !== 0 || I !== 0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_clear: v=%b R=%h S=%h I=%h rdy=%b, need 0/0/0/0/1",
               out_valid, R, S, I, in_ready);
    end
    #1 rst = 0;
    imm_model = 0;
    out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_stale: out_valid=%b cycle %0d, need 0", out_valid, c);
      end
    end
    in_valid = 1; sel_I = 3;
    @(negedge clk);
    in_valid = 0;
    n_tests++;
    if (out_valid !== 1'b1 || I !== 24'h000000) begin
      n_fail++;
      $display("FAIL rst_mid_imm: v=%b I=%h, need imm 000000", out_valid, I);
    end
    drain();
  endtask

  task automatic test_random();
    logic [3*W-1:0] q[$];
    logic [3*W-1:0] e;
    int x_errs;
    x_errs = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if ($isunknown({out_valid, in_ready, R, S, I, msb_R, msb_S})) x_errs++;
      n_tests++;
      if (out_valid !== (q.size() > 0)) begin
        n_fail++;
        $display("FAIL rand_valid: cycle %0d out_valid=%b, model depth %0d", c, out_valid, q.size());
      end
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      sel_R = SELW'($urandom_range(7)); inv_R = $urandom_range(1);
      sel_S = SELW'($urandom_range(7)); inv_S = $urandom_range(1);
      sel_I = 2'($urandom_range(3));
      imm_we = ($urandom_range(4) == 0); imm_data = W'($urandom);
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if ({R, S, I} !== e || msb_R !== e[3*W-1] || msb_S !== e[2*W-1]) begin
          n_fail++;
          $display("FAIL rand_data: cycle %0d got %h msb=%b%b, need %h", c, {R, S, I}, msb_R, msb_S, e);
        end
      end
      if (in_valid && in_ready)
        q.push_back({ref_op(int'(sel_R), inv_R), ref_op(int'(sel_S), inv_S), ref_imm(int'(sel_I), imm_model)});
      if (imm_we) imm_model = imm_data;
    end
    imm_we = 0;
    n_tests++;
    if (x_errs !== 0) begin
      n_fail++;
      $display("FAIL rand_x: %0d cycles with X on outputs, need 0", x_errs);
    end
    drain();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; imm_model = 0;
    src_bus = {24'hC0FFEE, 24'h0FF00D, 24'hABCDEF, 24'h123456};
    test_reset();
    test_select();
    test_backpressure();
    test_throughput();
    test_imm_hazard();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
